kw11l_timer: RTL and testbench
==============================

Name: kw11l_timer

Overview:
- Parametrised successor to the KW11-L line clock embedded in the processor board: a Wishbone slave holding the line-clock CSR, an internal prescaler, and a vectored interrupt source with priority-handshake ports.
- Adds over the fixed 50 Hz clock:
  - two selectable tick rates;
  - an overrun flag;
  - parametrised address, vector and reference clock;
  - registered vector acknowledge.
- Sits on the CPU bus-side I/O page. Its irq_o drives one virq level of the board's interrupt arbiter.

Parameters:
- CLKREF, 50000000, clk_p frequency in Hz.
- RATE0, 50, tick rate in Hz when CSR[0]=0.
- RATE1, 60, tick rate in Hz when CSR[0]=1.
- CSR_ADDR, 16'o177546, CSR byte address; must be even.
- VECTOR, 9'o100, interrupt vector presented on acknowledge.

Ports:
- clk_p  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_init  in  1  synchronous bus reset (RESET instruction / power-up init), active high.
- wb_adr_i  in  16  byte address; bits [15:1] are compared.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data; 0 when not selected, so it can be OR-muxed.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  2  byte lanes.
- wb_stb_i  in  1  bus strobe, already qualified with cyc and I/O page.
- wb_ack_o  out  1  transfer acknowledge.
- irq_o  out  1  interrupt request.
- istb_i  in  1  vector strobe from the priority arbiter.
- ivec_o  out  9  vector, VECTOR while istb_i=1, else 0.
- iack_o  out  1  vector acknowledge.

Behaviour:
- sel = wb_stb_i & (wb_adr_i[15:1] == CSR_ADDR[15:1]).
- CSR layout:
  - bit 15 OVR: read-only, cleared by any CSR write.
  - bit 7 RDY: R/W.
  - bit 6 IE: R/W.
  - bit 0 RSEL: R/W, 0 selects RATE0, 1 selects RATE1.
  - All other bits read 0.
- Write lanes: wb_sel_i[0] gates writes to bits 7, 6 and 0. wb_sel_i[1] has no writable bits, but any write with sel still clears OVR.
- Ack:
  - wb_ack_o <= sel & ~wb_ack_o, giving a one-cycle pulse one clock after sel.
  - A strobe held high produces an ack every second cycle.
  - The register write occurs in the cycle that ack is generated (sel & ~wb_ack_o), once per access.
- Read data: wb_dat_o = sel ? CSR : 0, combinational.
- Prescaler:
  - 32-bit counter; DIV = CLKREF/RATEx - 1, integer division (truncate).
  - At cnt==DIV: cnt<=0 and tick<=1 for one cycle; otherwise cnt++ and tick<=0.
  - A write that changes RSEL forces cnt<=0 and suppresses the tick in that cycle.
  - The prescaler runs regardless of IE and bus_init. It is reset only by rst_n.
- Tick event (tick=1):
  - RDY<=1.
  - If RDY was already 1, OVR<=1.
  - If IE (current registered value) is 1, irq<=1.
- irq clear: irq<=0 when IE=0, or on istb_i=1.
- Simultaneous events:
  - tick and a write clearing RDY in the same cycle → RDY=1. IE/RSEL take the written value.
  - tick and istb_i in the same cycle → irq stays 1 (a new request).
  - tick and a write clearing OVR → OVR is set if RDY was 1 before the cycle (set wins).
- Vector:
  - ivec_o = istb_i ? VECTOR : 0.
  - iack_o <= istb_i & ~iack_o: one-cycle pulse, one clock after istb_i, then low for one cycle.
- bus_init (synchronous): IE=0, RDY=1, OVR=0, RSEL=0, irq=0, wb_ack_o=0, iack_o=0. The prescaler is not reset.
- rst_n=0 (asynchronous, any time including mid-access): all registers cleared as for bus_init, and cnt=0, tick=0. Outputs after reset: wb_ack_o=0, irq_o=0, iack_o=0, wb_dat_o=0 (no sel).
- An access in flight when reset asserts is dropped. No ack is issued after release unless the strobe is still present.

Test Plan:
- Reset/read (CLKREF=1000, RATE0=50, RATE1=60): release rst_n, read 177546 before the first tick → dat=16'o000200, one ack pulse exactly one cycle after strobe.
- 50 Hz ticks: write 16'o000100 (IE=1, RDY=0) → ticks every 20 clocks. At the first tick, RDY=1 and irq_o=1. istb_i pulse → ivec_o=9'o100, iack_o pulse on the next cycle, irq_o low the cycle after istb_i.
- Rate switch: write 16'o000001 mid-count → counter restarts, next tick 17 clocks after the write (DIV=15), then every 16 clocks. Write 0 → period returns to 20.
- Overrun: IE=0, let two ticks pass without clearing RDY → read shows 16'o100200. Write 0 → read shows 0 until the next tick.
- Collisions: write RDY=0 in the tick cycle → RDY reads 1. Assert istb_i in the tick cycle with IE=1 → irq_o remains 1.
- Init/async reset: pending irq with IE=1, pulse bus_init → irq_o=0, CSR=16'o000200, tick phase unchanged. Assert rst_n low mid-strobe → wb_ack_o=0 immediately, CSR=16'o000200 after release.

Source files
------------

// File: rtl/kw11l_timer.sv
// KW11-L style line clock: Wishbone CSR slave, selectable-rate prescaler and
// vectored interrupt source with a registered arbiter acknowledge.
module kw11l_timer #(
    parameter int unsigned CLKREF   = 50000000,
    parameter int unsigned RATE0    = 50,
    parameter int unsigned RATE1    = 60,
    parameter logic [15:0] CSR_ADDR = 16'o177546,
    parameter logic [8:0]  VECTOR   = 9'o100
) (
    input  logic        clk_p,
    input  logic        rst_n,
    input  logic        bus_init,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        irq_o,
    input  logic        istb_i,
    output logic [8:0]  ivec_o,
    output logic        iack_o
);

    localparam logic [31:0] DIV0 = 32'(CLKREF / RATE0 - 1);
    localparam logic [31:0] DIV1 = 32'(CLKREF / RATE1 - 1);

    logic        sel;
    logic        wr;
    logic        wr_lo;
    logic        rsel_chg;
    logic [31:0] div;
    logic [31:0] cnt;
    logic        tick;
    logic        rdy;
    logic        ie;
    logic        rsel;
    logic        ovr;
    logic        irq;
    logic        ack;
    logic        iack;
    logic        unused_bits;

    assign sel      = wb_stb_i & (wb_adr_i[15:1] == CSR_ADDR[15:1]);
    // The write happens only on the ack-generating cycle, so a held strobe writes once per ack.
    assign wr       = sel & ~ack & wb_we_i & ~bus_init;
    assign wr_lo    = wr & wb_sel_i[0];
    assign rsel_chg = wr_lo & (wb_dat_i[0] != rsel);
    assign div      = rsel ? DIV1 : DIV0;

    // Prescaler: only rst_n resets it; >= guards against a rate drop via bus_init.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (rsel_chg) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt >= div) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 32'd1;
            tick <= 1'b0;
        end
    end

    // Later assignments win, so tick-driven sets override same-cycle clears.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            rdy  <= 1'b1;
            ie   <= 1'b0;
            rsel <= 1'b0;
            ovr  <= 1'b0;
            irq  <= 1'b0;
            ack  <= 1'b0;
            iack <= 1'b0;
        end else if (bus_init) begin
            rdy  <= 1'b1;
            ie   <= 1'b0;
            rsel <= 1'b0;
            ovr  <= 1'b0;
            irq  <= 1'b0;
            ack  <= 1'b0;
            iack <= 1'b0;
        end else begin
            ack  <= sel & ~ack;
            iack <= istb_i & ~iack;
            if (wr_lo) begin
                rdy  <= wb_dat_i[7];
                ie   <= wb_dat_i[6];
                rsel <= wb_dat_i[0];
            end
            if (tick) begin
                rdy <= 1'b1;
            end
            if (wr) begin
                ovr <= 1'b0;
            end
            if (tick && rdy) begin
                ovr <= 1'b1;
            end
            if (!ie || istb_i) begin
                irq <= 1'b0;
            end
            if (tick && ie) begin
                irq <= 1'b1;
            end
        end
    end

    assign wb_dat_o = sel ? {ovr, 7'b0, rdy, ie, 5'b0, rsel} : '0;
    assign wb_ack_o = ack;
    assign irq_o    = irq;
    assign iack_o   = iack;
    assign ivec_o   = istb_i ? VECTOR : '0;

    assign unused_bits = &{1'b0, wb_adr_i[0], wb_dat_i[15:8], wb_dat_i[5:1], wb_sel_i[1]};

endmodule

// File: tb/tb_kw11l_timer.sv
// Directed bench for kw11l_timer with CLKREF=1000: 50 Hz gives DIV=19, 60 Hz gives DIV=15.
module tb_kw11l_timer;

    localparam logic [15:0] CSR = 16'o177546;

    logic        clk_p    = 1'b0;
    logic        rst_n    = 1'b0;
    logic        bus_init = 1'b0;
    logic [15:0] wb_adr_i = '0;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic        wb_we_i  = 1'b0;
    logic [1:0]  wb_sel_i = '0;
    logic        wb_stb_i = 1'b0;
    logic        wb_ack_o;
    logic        irq_o;
    logic        istb_i   = 1'b0;
    logic [8:0]  ivec_o;
    logic        iack_o;

    int unsigned cyc    = 0;
    int unsigned tphase = 0;
    int          n_pass = 0;
    int          n_tot  = 0;

    kw11l_timer #(
        .CLKREF  (1000),
        .RATE0   (50),
        .RATE1   (60),
        .CSR_ADDR(16'o177546),
        .VECTOR  (9'o100)
    ) dut (
        .clk_p   (clk_p),
        .rst_n   (rst_n),
        .bus_init(bus_init),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_we_i (wb_we_i),
        .wb_sel_i(wb_sel_i),
        .wb_stb_i(wb_stb_i),
        .wb_ack_o(wb_ack_o),
        .irq_o   (irq_o),
        .istb_i  (istb_i),
        .ivec_o  (ivec_o),
        .iack_o  (iack_o)
    );

    always #5 clk_p = ~clk_p;
    always @(posedge clk_p) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk_p);
        #1;
    endtask

    task automatic bus_wr(input logic [15:0] d, output int unsigned wr_at);
        wb_adr_i = CSR;
        wb_dat_i = d;
        wb_we_i  = 1'b1;
        wb_sel_i = 2'b11;
        wb_stb_i = 1'b1;
        step();
        wr_at    = cyc;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        step();
    endtask

    task automatic bus_rd(output logic [15:0] d);
        wb_adr_i = CSR;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        #1;
        d = wb_dat_o;
        step();
        wb_stb_i = 1'b0;
        step();
    endtask

    task automatic do_istb();
        istb_i = 1'b1;
        step();
        istb_i = 1'b0;
    endtask

    task automatic wait_irq(input int maxc, output int unsigned t);
        t = 0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (irq_o === 1'b1) begin
                t = cyc;
                return;
            end
        end
    endtask

    task automatic wait_off(input int unsigned off);
        while (((cyc - tphase) % 20) != off) step();
    endtask

    int unsigned rel;

    task automatic test_reset();
        logic [15:0] d;
        step();
        step();
        n_tot++; if (wb_ack_o !== 1'b0) $display("FAIL rst_ack: got %b want 0", wb_ack_o); else n_pass++;
        n_tot++; if (irq_o !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq_o); else n_pass++;
        n_tot++; if (iack_o !== 1'b0) $display("FAIL rst_iack: got %b want 0", iack_o); else n_pass++;
        n_tot++; if (wb_dat_o !== 16'o0) $display("FAIL rst_dat: got %o want 0", wb_dat_o); else n_pass++;
        rst_n = 1'b1;
        rel = cyc;
        wb_adr_i = CSR;
        wb_stb_i = 1'b1;
        #1;
        n_tot++; if (wb_dat_o !== 16'o000200) $display("FAIL rd_dat: got %o want 200", wb_dat_o); else n_pass++;
        n_tot++; if (wb_ack_o !== 1'b0) $display("FAIL rd_ack_pre: got %b want 0", wb_ack_o); else n_pass++;
        step();
        n_tot++; if (wb_ack_o !== 1'b1) $display("FAIL rd_ack1: got %b want 1", wb_ack_o); else n_pass++;
        step();
        n_tot++; if (wb_ack_o !== 1'b0) $display("FAIL held_ack2: got %b want 0", wb_ack_o); else n_pass++;
        step();
        n_tot++; if (wb_ack_o !== 1'b1) $display("FAIL held_ack3: got %b want 1", wb_ack_o); else n_pass++;
        wb_stb_i = 1'b0;
        step();
        n_tot++; if (wb_ack_o !== 1'b0) $display("FAIL rd_ack_end: got %b want 0", wb_ack_o); else n_pass++;
        wb_adr_i = 16'o177550;
        wb_stb_i = 1'b1;
        #1;
        n_tot++; if (wb_dat_o !== 16'o0) $display("FAIL nosel_dat: got %o want 0", wb_dat_o); else n_pass++;
        step();
        n_tot++; if (wb_ack_o !== 1'b0) $display("FAIL nosel_ack: got %b want 0", wb_ack_o); else n_pass++;
        wb_stb_i = 1'b0;
        wb_adr_i = 16'o177547;
        wb_stb_i = 1'b1;
        #1;
        n_tot++; if (wb_dat_o !== 16'o000200) $display("FAIL odd_dat: got %o want 200", wb_dat_o); else n_pass++;
        step();
        wb_stb_i = 1'b0;
        step();
        bus_rd(d);
    endtask

    task automatic test_ticks();
        int unsigned w, t1, t2;
        logic [15:0] d;
        bus_wr(16'o000100, w);
        wait_irq(40, t1);
        n_tot++; if (t1 - rel != 21) $display("FAIL first_tick: got %0d want 21", t1 - rel); else n_pass++;
        bus_rd(d);
        n_tot++; if (d !== 16'o000300) $display("FAIL tick_csr: got %o want 300", d); else n_pass++;
        istb_i = 1'b1;
        #1;
        n_tot++; if (ivec_o !== 9'o100) $display("FAIL ivec: got %o want 100", ivec_o); else n_pass++;
        n_tot++; if (iack_o !== 1'b0) $display("FAIL iack_pre: got %b want 0", iack_o); else n_pass++;
        n_tot++; if (irq_o !== 1'b1) $display("FAIL irq_pend: got %b want 1", irq_o); else n_pass++;
        step();
        n_tot++; if (iack_o !== 1'b1) $display("FAIL iack: got %b want 1", iack_o); else n_pass++;
        n_tot++; if (irq_o !== 1'b0) $display("FAIL irq_clr: got %b want 0", irq_o); else n_pass++;
        istb_i = 1'b0;
        #1;
        n_tot++; if (ivec_o !== 9'o0) $display("FAIL ivec_idle: got %o want 0", ivec_o); else n_pass++;
        step();
        n_tot++; if (iack_o !== 1'b0) $display("FAIL iack_end: got %b want 0", iack_o); else n_pass++;
        wait_irq(40, t2);
        n_tot++; if (t2 - t1 != 20) $display("FAIL period50: got %0d want 20", t2 - t1); else n_pass++;
    endtask

    task automatic test_rate_switch();
        int unsigned w, t3, t4, t5, t6;
        logic [15:0] d;
        do_istb();
        bus_wr(16'o000101, w);
        bus_rd(d);
        n_tot++; if (d !== 16'o000101) $display("FAIL rsel_csr: got %o want 101", d); else n_pass++;
        wait_irq(40, t3);
        n_tot++; if (t3 - w != 17) $display("FAIL switch60: got %0d want 17", t3 - w); else n_pass++;
        do_istb();
        wait_irq(40, t4);
        n_tot++; if (t4 - t3 != 16) $display("FAIL period60: got %0d want 16", t4 - t3); else n_pass++;
        do_istb();
        bus_wr(16'o000100, w);
        wait_irq(40, t5);
        n_tot++; if (t5 - w != 21) $display("FAIL switch50: got %0d want 21", t5 - w); else n_pass++;
        do_istb();
        wait_irq(40, t6);
        n_tot++; if (t6 - t5 != 20) $display("FAIL period50b: got %0d want 20", t6 - t5); else n_pass++;
        tphase = t6;
    endtask

    task automatic test_overrun();
        int unsigned w;
        logic [15:0] d;
        bus_wr(16'o000000, w);
        n_tot++; if (irq_o !== 1'b0) $display("FAIL ie_off_irq: got %b want 0", irq_o); else n_pass++;
        repeat (45) step();
        bus_rd(d);
        n_tot++; if (d !== 16'o100200) $display("FAIL ovr_csr: got %o want 100200", d); else n_pass++;
        n_tot++; if (irq_o !== 1'b0) $display("FAIL ovr_irq: got %b want 0", irq_o); else n_pass++;
        wait_off(3);
        bus_wr(16'o000000, w);
        bus_rd(d);
        n_tot++; if (d !== 16'o0) $display("FAIL ovr_clr: got %o want 0", d); else n_pass++;
        wait_off(1);
        bus_rd(d);
        n_tot++; if (d !== 16'o000200) $display("FAIL rdy_again: got %o want 200", d); else n_pass++;
    endtask

    task automatic test_collisions();
        int unsigned w;
        logic [15:0] d;
        wait_off(19);
        bus_wr(16'o000000, w);
        bus_rd(d);
        n_tot++; if (d !== 16'o100200) $display("FAIL wr_tick: got %o want 100200", d); else n_pass++;
        wait_off(5);
        bus_wr(16'o000100, w);
        wait_off(1);
        n_tot++; if (irq_o !== 1'b1) $display("FAIL irq_set: got %b want 1", irq_o); else n_pass++;
        wait_off(19);
        istb_i = 1'b1;
        step();
        n_tot++; if (irq_o !== 1'b1) $display("FAIL istb_tick: got %b want 1", irq_o); else n_pass++;
        istb_i = 1'b0;
        bus_rd(d);
        n_tot++; if (d !== 16'o100300) $display("FAIL coll_csr: got %o want 100300", d); else n_pass++;
    endtask

    task automatic test_init();
        int unsigned w, t;
        logic [15:0] d;
        wait_off(5);
        bus_init = 1'b1;
        step();
        bus_init = 1'b0;
        n_tot++; if (irq_o !== 1'b0) $display("FAIL init_irq: got %b want 0", irq_o); else n_pass++;
        bus_rd(d);
        n_tot++; if (d !== 16'o000200) $display("FAIL init_csr: got %o want 200", d); else n_pass++;
        bus_wr(16'o000100, w);
        wait_irq(40, t);
        n_tot++; if (t == 0 || ((t - tphase) % 20) != 0)
            $display("FAIL init_phase: got offset %0d want 0", (t - tphase) % 20);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int unsigned w, t, rel2;
        logic [15:0] d;
        wb_adr_i = CSR;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        step();
        n_tot++; if (wb_ack_o !== 1'b1) $display("FAIL pre_rst_ack: got %b want 1", wb_ack_o); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_tot++; if (wb_ack_o !== 1'b0) $display("FAIL async_ack: got %b want 0", wb_ack_o); else n_pass++;
        n_tot++; if (irq_o !== 1'b0) $display("FAIL async_irq: got %b want 0", irq_o); else n_pass++;
        step();
        n_tot++; if (wb_ack_o !== 1'b0) $display("FAIL rst_held_ack: got %b want 0", wb_ack_o); else n_pass++;
        wb_stb_i = 1'b0;
        rst_n    = 1'b1;
        rel2     = cyc;
        step();
        step();
        n_tot++; if (wb_ack_o !== 1'b0) $display("FAIL post_rst_ack: got %b want 0", wb_ack_o); else n_pass++;
        bus_rd(d);
        n_tot++; if (d !== 16'o000200) $display("FAIL post_rst_csr: got %o want 200", d); else n_pass++;
        bus_wr(16'o000100, w);
        wait_irq(40, t);
        n_tot++; if (t - rel2 != 21) $display("FAIL post_rst_tick: got %0d want 21", t - rel2); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ticks();
        test_rate_switch();
        test_overrun();
        test_collisions();
        test_init();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
